// File: rtl/edge_event_scheduler.sv
// Per-channel edge/pulse detector feeding a single-entry valid/ready event slot.
// Channels are served round-robin; a new event on a channel that is still pending is dropped and flagged.
module edge_event_scheduler #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in,
  input  logic [2*N-1:0] mode,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic [1:0]     evt_kind,
  output logic [N-1:0]   overflow,
  input  logic           ovf_clr
);

  logic [N-1:0]   h1, h2;
  logic [N-1:0]   det;
  logic [N-1:0]   pending, pending_nxt;
  logic [N-1:0]   load_sel, ovf_set, kind_we;
  logic [1:0]     pkind [N];
  logic [IDW-1:0] last_grant, winner;
  logic           found, slot_free, load;

  always_comb begin
    det = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[2*i +: 2])
        2'b01:   det[i] = in[i] & ~h1[i];
        2'b10:   det[i] = ~in[i] & h1[i];
        2'b11:   det[i] = ~in[i] & h1[i] & ~h2[i];
        default: det[i] = 1'b0;
      endcase
    end
  end

  // Search starts just after the last granted channel so every channel gets a turn.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && pending[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign slot_free = !evt_valid || evt_ready;
  assign load      = slot_free && found;

  // A channel being loaded this edge may accept a fresh detect; otherwise a detect on a pending channel is dropped.
  always_comb begin
    load_sel    = '0;
    ovf_set     = '0;
    kind_we     = '0;
    pending_nxt = '0;
    for (int i = 0; i < N; i++) begin
      load_sel[i]    = load && (winner == IDW'(i));
      ovf_set[i]     = det[i] & pending[i] & ~load_sel[i];
      kind_we[i]     = det[i] & ~ovf_set[i];
      pending_nxt[i] = (pending[i] & ~load_sel[i]) | det[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1         <= '0;
      h2         <= '0;
      pending    <= '0;
      overflow   <= '0;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_kind   <= 2'b00;
      last_grant <= IDW'(N - 1);
      for (int i = 0; i < N; i++) pkind[i] <= 2'b00;
    end else begin
      h1       <= in;
      h2       <= h1;
      pending  <= pending_nxt;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
      for (int i = 0; i < N; i++) begin
        if (kind_we[i]) pkind[i] <= mode[2*i +: 2];
      end
      if (slot_free) begin
        if (found) begin
          evt_valid  <= 1'b1;
          evt_id     <= winner;
          evt_kind   <= pkind[winner];
          last_grant <= winner;
        end else begin
          evt_valid  <= 1'b0;
        end
      end
    end
  end

endmodule
